dma_addr_gen: RTL



---
 rtl/dma_addr_gen_if.sv | 27 ++
 rtl/dma_addr_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dma_addr_gen_if.sv
// Bus between the microprogram sequencer and the DMA address/word-count
// generator. The sequencer drives instructions, load data and count enables;
// the generator returns carries, the done flag, read-back data and the address.
interface dma_addr_gen_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       instr;
  logic             instr_valid;
  logic [WIDTH-1:0] data_in;
  logic             aci;
  logic             wci;
  logic             aco;
  logic             wco;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] addr_out;

  modport master (
    output instr, instr_valid, data_in, aci, wci,
    input  aco, wco, done, data_out, addr_out
  );

  modport slave (
    input  instr, instr_valid, data_in, aci, wci,
    output aco, wco, done, data_out, addr_out
  );
endinterface

// File: rtl/dma_addr_gen.sv
// Parametrised DMA address/word-count generator with IDLE/RUN/DONE run state.
// Optional feature: define DMA_AUTO_RELOAD_EN to implement CR[3] auto-reload
// (reload AC/WC and pulse done instead of stopping). Without it CR[3] is not
// stored, reads back as 0, and every done condition stops in DONE.
module dma_addr_gen #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  dma_addr_gen_if.slave bus
);

  localparam logic [2:0] WRCR   = 3'b000;
  localparam logic [2:0] RDCR   = 3'b001;
  localparam logic [2:0] RDWC   = 3'b010;
  localparam logic [2:0] RDAC   = 3'b011;
  localparam logic [2:0] REINIT = 3'b100;
  localparam logic [2:0] LDADDR = 3'b101;
  localparam logic [2:0] LDWC   = 3'b110;
  localparam logic [2:0] ENCT   = 3'b111;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           stateReg, stateNext;
  logic [1:0]       modeReg, modeNext;
  logic             decReg, decNext;
  logic [WIDTH-1:0] arReg, arNext;
  logic [WIDTH-1:0] acReg, acNext;
  logic [WIDTH-1:0] wcrReg, wcrNext;
  logic [WIDTH-1:0] wcReg, wcNext;
  logic [WIDTH-1:0] dataOutReg, dataOutNext;
`ifdef DMA_AUTO_RELOAD_EN
  logic             reloadEnReg, reloadEnNext;
  logic             pulseReg, pulseNext;
`endif

  logic             isCtl, running, counting, acStep, wcStep, wcDown, doneCond;
  logic [WIDTH-1:0] acAfter, wcAfter, reloadVal;
  logic [3:0]       crVal;

  // Counting is suppressed by any instruction that rewrites registers or state;
  // read-backs and ENCT let the step proceed in the same cycle.
  assign isCtl = bus.instr_valid &&
                 (bus.instr == WRCR || bus.instr == REINIT ||
                  bus.instr == LDADDR || bus.instr == LDWC);
  assign running  = (stateReg == RUN);
  assign counting = running && !isCtl;
  assign acStep   = counting && bus.aci;
  assign wcStep   = counting && bus.wci;
  assign wcDown   = (modeReg == 2'b01);

  assign acAfter   = acStep ? (decReg ? acReg - ONE : acReg + ONE) : acReg;
  assign wcAfter   = wcStep ? (wcDown ? wcReg - ONE : wcReg + ONE) : wcReg;
  assign reloadVal = wcDown ? wcrReg : ZERO;

`ifdef DMA_AUTO_RELOAD_EN
  assign crVal = {reloadEnReg, decReg, modeReg};
`else
  assign crVal = {1'b0, decReg, modeReg};
`endif

  // Done condition, judged on the post-step counter values of this cycle.
  always_comb begin
    doneCond = 1'b0;
    case (modeReg)
      2'b00:   doneCond = wcStep && (wcAfter == wcrReg);
      2'b01:   doneCond = wcStep && (wcAfter == ZERO);
      2'b10:   doneCond = acStep && (acAfter == wcrReg);
      default: doneCond = wcStep && (wcReg == ALL_ONES);
    endcase
  end

  // Next-state and register updates: instruction decode, counting, done handling.
  always_comb begin
    stateNext   = stateReg;
    modeNext    = modeReg;
    decNext     = decReg;
    arNext      = arReg;
    acNext      = acAfter;
    wcrNext     = wcrReg;
    wcNext      = wcAfter;
    dataOutNext = dataOutReg;
`ifdef DMA_AUTO_RELOAD_EN
    reloadEnNext = reloadEnReg;
    pulseNext    = 1'b0;
`endif
    if (bus.instr_valid) begin
      case (bus.instr)
        WRCR: begin
          modeNext  = bus.data_in[1:0];
          decNext   = bus.data_in[2];
`ifdef DMA_AUTO_RELOAD_EN
          reloadEnNext = bus.data_in[3];
`endif
          stateNext = IDLE;
        end
        RDCR: dataOutNext = {{(WIDTH-4){1'b0}}, crVal};
        RDWC: dataOutNext = wcReg;
        RDAC: dataOutNext = acReg;
        REINIT: begin
          acNext    = arReg;
          wcNext    = reloadVal;
          stateNext = IDLE;
        end
        LDADDR: begin
          arNext    = bus.data_in;
          acNext    = bus.data_in;
          stateNext = IDLE;
        end
        LDWC: begin
          wcrNext   = bus.data_in;
          wcNext    = wcDown ? bus.data_in : ZERO;
          stateNext = IDLE;
        end
        default: begin
          if (stateReg == IDLE) stateNext = RUN;
        end
      endcase
    end
    if (doneCond) begin
`ifdef DMA_AUTO_RELOAD_EN
      if (reloadEnReg) begin
        acNext    = arReg;
        wcNext    = reloadVal;
        pulseNext = 1'b1;
      end else begin
        stateNext = DONE;
      end
`else
      stateNext = DONE;
`endif
    end
  end

  // State and register file, synchronously cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      modeReg    <= 2'b00;
      decReg     <= 1'b0;
      arReg      <= ZERO;
      acReg      <= ZERO;
      wcrReg     <= ZERO;
      wcReg      <= ZERO;
      dataOutReg <= ZERO;
`ifdef DMA_AUTO_RELOAD_EN
      reloadEnReg <= 1'b0;
      pulseReg    <= 1'b0;
`endif
    end else begin
      stateReg   <= stateNext;
      modeReg    <= modeNext;
      decReg     <= decNext;
      arReg      <= arNext;
      acReg      <= acNext;
      wcrReg     <= wcrNext;
      wcReg      <= wcNext;
      dataOutReg <= dataOutNext;
`ifdef DMA_AUTO_RELOAD_EN
      reloadEnReg <= reloadEnNext;
      pulseReg    <= pulseNext;
`endif
    end
  end

  assign bus.aco = running && bus.aci && (decReg ? (acReg == ZERO) : (acReg == ALL_ONES));
  assign bus.wco = running && bus.wci && (wcDown ? (wcReg == ZERO) : (wcReg == ALL_ONES));
`ifdef DMA_AUTO_RELOAD_EN
  assign bus.done = (stateReg == DONE) || pulseReg;
`else
  assign bus.done = (stateReg == DONE);
`endif
  assign bus.data_out = dataOutReg;
  assign bus.addr_out = acReg;

endmodule
